dmux_result_bank: RTL

DMUX_RESULT_BANK -- requirements
Module: dmux_result_bank

---
 rtl/dmux_result_bank.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmux_result_bank.sv
// Result bank: captures one demux lane per write into an 8-entry
// register file and drains occupied entries in index order.
module dmux_result_bank #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic [WIDTH-1:0] A4,
  input  logic [WIDTH-1:0] A5,
  input  logic [WIDTH-1:0] A6,
  input  logic [WIDTH-1:0] A7,
  input  logic [2:0]       SEL,
  input  logic             WR_EN,
  output logic             WR_READY,
  input  logic             DRAIN,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [2:0]       OUT_IDX,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [LANES-1:0] VALID,
  output logic             BUSY,
  output logic             OVF,
  input  logic             CLR_OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] regs_q [LANES];
  logic [WIDTH-1:0] regs_d [LANES];
  logic [LANES-1:0] valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lanes [LANES];
  logic             wr_ok;

  always_comb begin
    lanes[0] = A0;
    lanes[1] = A1;
    lanes[2] = A2;
    lanes[3] = A3;
    lanes[4] = A4;
    lanes[5] = A5;
    lanes[6] = A6;
    lanes[7] = A7;
  end

  assign WR_READY  = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);
  assign VALID     = valid_q;
  assign OVF       = ovf_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_IDX   = out_idx_q;
  assign OUT_VALID = out_valid_q;
  assign wr_ok     = WR_EN && WR_READY;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;

    if (CLR_OVF) ovf_d = 1'b0;
    // Overwrite wins over a coincident clear.
    if (wr_ok) begin
      regs_d[SEL]  = lanes[SEL];
      valid_d[SEL] = 1'b1;
      if (valid_q[SEL]) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (DRAIN) begin
          ptr_d   = 3'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_q[ptr_q]) begin
          out_data_d  = regs_q[ptr_q];
          out_idx_d   = ptr_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end else if (ptr_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 3'd1;
        end
      end
      SEND: begin
        if (out_valid_q && OUT_READY) begin
          out_valid_d    = 1'b0;
          valid_d[ptr_q] = 1'b0;
          if (ptr_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            ptr_d   = ptr_q + 3'd1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      valid_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 3'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < LANES; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule
